// File: rtl/itr_ctrl_if.sv
// Bundle of the interrupt controller's event, core-output and status signals.
//   src       : interrupt event lines (rising-edge sensitive)
//   out_en    : core output strobe
//   addr_out  : core output address
//   data_out  : core output data (mask in the low NSRC bits)
//   itr       : one-cycle interrupt pulse to the core
//   itr_id    : index of the source in service
//   busy      : high from grant until end-of-interrupt
//   pending   : pending request register (status)
// master: the side driving events and core writes; slave: the controller.
interface itr_ctrl_if #(
  parameter int NSRC   = 4,
  parameter int NBDATA = 23,
  parameter int NUIOOU = 8
);
  localparam int IDW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int AW  = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  logic [NSRC-1:0]   src;
  logic              out_en;
  logic [AW-1:0]     addr_out;
  logic [NBDATA-1:0] data_out;
  logic              itr;
  logic [IDW-1:0]    itr_id;
  logic              busy;
  logic [NSRC-1:0]   pending;

  modport master (
    output src, out_en, addr_out, data_out,
    input  itr, itr_id, busy, pending
  );

  modport slave (
    input  src, out_en, addr_out, data_out,
    output itr, itr_id, busy, pending
  );
endinterface

// File: rtl/itr_ctrl.sv
// Interrupt controller for the core's single-bit itr input.
// Latches rising edges of NSRC event lines as pending requests, masks them
// under software control (write to MSKADR), grants the lowest-index eligible
// request, emits a one-cycle itr pulse and waits for an end-of-interrupt
// write (to EOIADR) before granting again.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : itr_ctrl_if slave modport (src, out_en, addr_out, data_out in;
//          itr, itr_id, busy, pending out)
module itr_ctrl #(
  parameter int NSRC   = 4,
  parameter int NBDATA = 23,
  parameter int NUIOOU = 8,
  parameter int MSKADR = 6,
  parameter int EOIADR = 7
) (
  input  logic       clk,
  input  logic       rst,
  itr_ctrl_if.slave  bus
);
  localparam int IDW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int AW  = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  typedef enum logic [1:0] {IDLE, FIRE, SRV} state_t;

  state_t          state, state_nxt;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] grant_clr;
  logic [IDW-1:0]  itr_id;
  logic [IDW-1:0]  grant_idx;
  logic            grant_hit;
  logic            grant;
  logic            mask_wr;
  logic            eoi_wr;
  logic            unused_data;

  assign unused_data = ^bus.data_out[NBDATA-1:NSRC];

  assign rise     = bus.src & ~src_q;
  assign eligible = pending & mask;
  assign mask_wr  = bus.out_en && (bus.addr_out == AW'(MSKADR));
  assign eoi_wr   = bus.out_en && (bus.addr_out == AW'(EOIADR));
  assign grant    = (state == IDLE) && grant_hit;

  // Fixed priority: the first hit scanning upward from index 0 wins.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (eligible[i] && !grant_hit) begin
        grant_hit = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end

  always_comb begin
    grant_clr = '0;
    if (grant) grant_clr[grant_idx] = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (grant_hit) state_nxt = FIRE;
      FIRE: state_nxt = SRV;
      SRV:  if (eoi_wr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so itr has no input path.
  always_comb begin
    bus.itr     = (state == FIRE);
    bus.busy    = (state != IDLE);
    bus.itr_id  = itr_id;
    bus.pending = pending;
  end

  // Datapath registers. A new rise on the source being granted wins over its
  // clear, so the OR with rise comes after the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q   <= bus.src;
      pending <= '0;
      mask    <= '0;
      itr_id  <= '0;
    end else begin
      src_q   <= bus.src;
      pending <= (pending & ~grant_clr) | rise;
      if (mask_wr) mask <= bus.data_out[NSRC-1:0];
      if (grant) itr_id <= grant_idx;
    end
  end
endmodule

// File: tb/tb_itr_ctrl.sv
module tb_itr_ctrl;
  localparam int NSRC   = 4;
  localparam int NBDATA = 23;
  localparam int NUIOOU = 8;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fail;

  itr_ctrl_if #(.NSRC(NSRC), .NBDATA(NBDATA), .NUIOOU(NUIOOU)) bus ();

  itr_ctrl #(
    .NSRC(NSRC), .NBDATA(NBDATA), .NUIOOU(NUIOOU), .MSKADR(6), .EOIADR(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs changed afterwards apply to the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [2:0] addr, input logic [NBDATA-1:0] data);
    bus.out_en   = 1'b1;
    bus.addr_out = addr;
    bus.data_out = data;
    tick();
    bus.out_en   = 1'b0;
    bus.data_out = '0;
  endtask

  task automatic pulse_src(input logic [NSRC-1:0] v);
    bus.src = v;
    tick();
    bus.src = '0;
  endtask

  initial begin
    int unsigned pulses;
    logic [31:0] seen_id;
    n_checks = 0;
    n_fail   = 0;
    rst          = 1'b0;
    bus.src      = 4'b1111;
    bus.out_en   = 1'b0;
    bus.addr_out = '0;
    bus.data_out = '0;

    // 1: reset with all lines high, release while held high
    repeat (3) tick();
    check("rst_itr", bus.itr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_itr_id", bus.itr_id, 0);
    rst = 1'b1;
    core_write(3'd6, 23'hF);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.itr) pulses++;
      tick();
    end
    check("rel_no_itr", pulses, 0);
    check("rel_pending", bus.pending, 0);
    bus.src = '0;
    tick();

    // 2: single source through the full cycle
    core_write(3'd6, 23'b0100);
    pulse_src(4'b0100);                      // edge E
    check("s_pend_E", bus.pending, 4'b0100);
    check("s_itr_E", bus.itr, 0);
    tick();                                  // E+1: grant
    check("s_itr_E1", bus.itr, 1);
    check("s_id", bus.itr_id, 2);
    check("s_busy", bus.busy, 1);
    check("s_pend_clr", bus.pending, 0);
    tick();
    check("s_itr_E2", bus.itr, 0);
    check("s_busy_srv", bus.busy, 1);
    tick();
    check("s_itr_srv", bus.itr, 0);
    core_write(3'd7, 23'h0);
    check("s_busy_eoi", bus.busy, 0);
    check("s_itr_eoi", bus.itr, 0);
    check("s_id_hold", bus.itr_id, 2);

    // 3: simultaneous requests served lowest index first
    core_write(3'd6, 23'hF);
    pulse_src(4'b1010);
    check("p_pend", bus.pending, 4'b1010);
    tick();
    check("p_itr1", bus.itr, 1);
    check("p_id1", bus.itr_id, 1);
    check("p_pend1", bus.pending, 4'b1000);
    tick();
    check("p_itr1_end", bus.itr, 0);
    core_write(3'd7, 23'h0);
    check("p_busy_eoi", bus.busy, 0);
    tick();
    check("p_itr2", bus.itr, 1);
    check("p_id2", bus.itr_id, 3);
    tick();
    core_write(3'd7, 23'h0);
    check("p_pend_end", bus.pending, 0);
    check("p_busy_end", bus.busy, 0);

    // 4: masked request stays pending until unmasked
    core_write(3'd6, 23'h0);
    pulse_src(4'b0001);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.itr) pulses++;
      tick();
    end
    check("m_no_itr", pulses, 0);
    check("m_pend", bus.pending, 4'b0001);
    check("m_busy", bus.busy, 0);
    core_write(3'd6, 23'h1);                 // edge M
    check("m_itr_M", bus.itr, 0);
    tick();                                  // M+1: grant
    check("m_itr_M1", bus.itr, 1);
    check("m_id", bus.itr_id, 0);
    tick();
    core_write(3'd7, 23'h0);

    // 5: events during service accumulate; stray EOI in IDLE ignored
    core_write(3'd6, 23'hF);
    pulse_src(4'b0001);
    tick();
    check("d_itr0", bus.itr, 1);
    tick();                                  // SRV
    pulse_src(4'b0100);
    tick();
    pulse_src(4'b0100);
    tick();
    check("d_pend", bus.pending, 4'b0100);
    check("d_itr_srv", bus.itr, 0);
    check("d_busy", bus.busy, 1);
    core_write(3'd7, 23'h0);
    pulses  = 0;
    seen_id = '1;
    for (int i = 0; i < 6; i++) begin
      if (bus.itr) begin
        pulses++;
        seen_id = 32'(bus.itr_id);
      end
      tick();
    end
    check("d_pulses", pulses, 1);
    check("d_id", seen_id, 2);
    core_write(3'd7, 23'h0);
    check("d_idle", bus.busy, 0);
    core_write(3'd7, 23'h0);                 // stray EOI in IDLE
    check("d_stray_busy", bus.busy, 0);
    check("d_stray_itr", bus.itr, 0);
    tick();
    check("d_stray_itr2", bus.itr, 0);
    check("d_stray_pend", bus.pending, 0);

    // 6: reset while in service with a request pending
    pulse_src(4'b0001);
    tick();
    tick();
    pulse_src(4'b1000);
    check("r_busy_pre", bus.busy, 1);
    check("r_pend_pre", bus.pending, 4'b1000);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("r_busy", bus.busy, 0);
    check("r_pend", bus.pending, 0);
    check("r_itr", bus.itr, 0);
    core_write(3'd6, 23'hF);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.itr) pulses++;
      tick();
    end
    check("r_no_itr", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
